// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory behind a single-outstanding valid/ready request port.
// Handles sub-word loads with sign or zero extension, misalignment errors and a configurable access latency.
module dmem_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic              r_we, r_unsigned;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [7:0] r_mem [DEPTH];

  logic              w_accept, w_access, w_use_in, w_err, w_wr_en;
  logic              w_we, w_unsigned;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_ld;
  logic [3:0]        w_be;
  logic [7:0]        w_b [4];

  assign req_ready  = (r_state != S_BUSY);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign w_accept   = req_valid && req_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entering RESP from outside BUSY means a LATENCY==1 accept: the access uses the live request.
  assign w_access   = (w_state_nxt == S_RESP);
  assign w_use_in   = (r_state != S_BUSY);
  assign w_we       = w_use_in ? req_we       : r_we;
  assign w_size     = w_use_in ? req_size     : r_size;
  assign w_unsigned = w_use_in ? req_unsigned : r_unsigned;
  assign w_addr     = w_use_in ? req_addr     : r_addr;
  assign w_wdata    = w_use_in ? req_wdata    : r_wdata;

  assign w_err = (w_size == 2'd3) ||
                 ((w_size == 2'd1) && w_addr[0]) ||
                 ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));

  always_comb begin
    w_be = 4'b0000;
    case (w_size)
      2'd0:    w_be = 4'b0001;
      2'd1:    w_be = 4'b0011;
      2'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) w_b[i] = r_mem[w_addr + ADDR_W'(i)];
  end

  always_comb begin
    w_ld = 32'd0;
    case (w_size)
      2'd0:    w_ld = {{24{~w_unsigned & w_b[0][7]}}, w_b[0]};
      2'd1:    w_ld = {{16{~w_unsigned & w_b[1][7]}}, w_b[1], w_b[0]};
      2'd2:    w_ld = {w_b[3], w_b[2], w_b[1], w_b[0]};
      default: w_ld = 32'd0;
    endcase
    if (w_we || w_err) w_ld = 32'd0;
  end

  // rst_n gate keeps a request presented during reset from reaching the array.
  assign w_wr_en = w_access && w_we && !w_err && rst_n;

  // NOTE: the data array is deliberately left out of reset; only control and response state are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_addr + ADDR_W'(i)] <= w_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (w_access) begin
        r_rdata <= w_ld;
        r_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three instances (LATENCY 1, 3, 4) checked against a byte-array model.
// Covers directed handshake/latency/reset cases plus random traffic confined to a preloaded 256-byte window.
module tb_dmem_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int LAT2 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, v2;
  logic        we, uns;
  logic [1:0]  sz;
  logic [15:0] addr;
  logic [31:0] wd;

  wire        rdy0, rdy1, rdy2;
  wire        rv0, rv1, rv2;
  wire [31:0] rd0, rd1, rd2;
  wire        er0, er1, er2;

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] mdl [3][65536];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(16), .LATENCY(LAT0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we), .req_size(sz),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wd), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));
  dmem_ctrl #(.ADDR_W(16), .LATENCY(LAT1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we), .req_size(sz),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wd), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));
  dmem_ctrl #(.ADDR_W(16), .LATENCY(LAT2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_we(we), .req_size(sz),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wd), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2));

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : (d == 1) ? LAT1 : LAT2;
  endfunction
  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic get_rv(input int d);
    return (d == 0) ? rv0 : (d == 1) ? rv1 : rv2;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
  endfunction
  function automatic logic get_er(input int d);
    return (d == 0) ? er0 : (d == 1) ? er1 : er2;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d == 0) v0 = v;
    else if (d == 1) v1 = v;
    else v2 = v;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte array, alignment rules and extension done with plain arithmetic.
  task automatic model_txn(input int d, input bit w, input bit [1:0] s, input bit u,
                           input bit [15:0] a, input bit [31:0] data,
                           output logic [31:0] exp_rd, output logic exp_er);
    int     ia = int'(a);
    int     nb;
    longint val, half;
    exp_er = (s == 2'd3) || (s == 2'd1 && ia % 2 != 0) || (s == 2'd2 && ia % 4 != 0);
    exp_rd = 32'd0;
    if (exp_er) return;
    nb = 1 << s;
    if (w) begin
      for (int i = 0; i < nb; i++) mdl[d][ia + i] = 8'((data >> (8 * i)) & 32'hFF);
    end else begin
      val = 0;
      for (int i = 0; i < nb; i++) val = val + (longint'(mdl[d][ia + i]) << (8 * i));
      half = longint'(1) << (8 * nb - 1);
      if (!u && nb < 4 && val >= half) val = val - 2 * half;
      exp_rd = 32'(val);
    end
  endtask

  task automatic txn(input int d, input bit w, input bit [1:0] s, input bit u,
                     input bit [15:0] a, input bit [31:0] data, input string tag);
    logic [31:0] erd;
    logic        eer;
    int          n;
    bit          ok;
    model_txn(d, w, s, u, a, data, erd, eer);
    @(negedge clk);
    we = w; sz = s; uns = u; addr = a; wd = data;
    set_valid(d, 1'b1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (get_rdy(d)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      set_valid(d, 1'b0);
      return;
    end
    @(posedge clk);
    #1;
    set_valid(d, 1'b0);
    we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom); addr = 16'($urandom); wd = $urandom;
    n = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (get_rv(d)) begin ok = 1; break; end
    end
    check({tag, "_lat"}, 32'(n), 32'(lat_of(d)));
    if (ok) begin
      check({tag, "_rdata"}, get_rd(d), erd);
      check({tag, "_err"}, 32'(get_er(d)), 32'(eer));
    end
  endtask

  logic [31:0] q_rd [$];
  logic        q_er [$];

  initial begin
    logic [31:0] erd;
    logic        eer;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    we = 1'b0; sz = 2'd0; uns = 1'b0; addr = 16'd0; wd = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(get_rdy(d)), 32'd1);
      check($sformatf("rst_valid%0d", d), 32'(get_rv(d)), 32'd0);
      check($sformatf("rst_rdata%0d", d), get_rd(d), 32'd0);
      check($sformatf("rst_err%0d", d), 32'(get_er(d)), 32'd0);
    end
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 256; a += 4) txn(d, 1'b1, 2'd2, 1'b0, 16'(a), 32'd0, "preload");
    end

    txn(0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, "st_word");
    txn(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, "ld_word");
    for (int i = 0; i < 4; i++) txn(0, 1'b0, 2'd0, 1'b1, 16'(16'h0010 + i), 32'h0, $sformatf("ld_byte%0d", i));
    txn(0, 1'b1, 2'd0, 1'b0, 16'h0021, 32'h00000080, "st_b80");
    txn(0, 1'b0, 2'd0, 1'b0, 16'h0021, 32'h0, "ld_b_signed");
    txn(0, 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, "ld_b_unsigned");
    txn(0, 1'b1, 2'd1, 1'b0, 16'h0022, 32'h00007FFF, "st_h7fff");
    txn(0, 1'b0, 2'd1, 1'b0, 16'h0022, 32'h0, "ld_h_signed");
    txn(0, 1'b1, 2'd2, 1'b0, 16'h0031, 32'h11223344, "st_misaligned");
    txn(0, 1'b0, 2'd2, 1'b0, 16'h0030, 32'h0, "ld_after_misaligned");
    txn(0, 1'b0, 2'd3, 1'b0, 16'h0040, 32'h0, "size3");

    // Back-to-back on LATENCY=1: alternating store/load to one address, one accept per cycle.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("b2b_valid%0d", k - 1), 32'(rv0), 32'd1);
        check($sformatf("b2b_rdata%0d", k - 1), rd0, q_rd.pop_front());
        check($sformatf("b2b_err%0d", k - 1), 32'(er0), 32'(q_er.pop_front()));
      end
      if (k < 8) begin
        we = (k % 2 == 0); sz = 2'd2; uns = 1'b0; addr = 16'h0060; wd = $urandom;
        v0 = 1'b1;
        model_txn(0, we, sz, uns, addr, wd, erd, eer);
        q_rd.push_back(erd);
        q_er.push_back(eer);
        check($sformatf("b2b_ready%0d", k), 32'(rdy0), 32'd1);
      end else begin
        v0 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_valid_fall", 32'(rv0), 32'd0);

    // LATENCY=3: two requests with req_valid held, second accepted in the first's RESP cycle.
    @(negedge clk);
    we = 1'b1; sz = 2'd2; uns = 1'b0; addr = 16'h0070; wd = 32'hA5A51234;
    v1 = 1'b1;
    model_txn(1, we, sz, uns, addr, wd, erd, eer);
    check("l3_ready_idle", 32'(rdy1), 32'd1);
    @(posedge clk);
    #1;
    we = 1'b0; sz = 2'd2; uns = 1'b0; addr = 16'h0070; wd = 32'h0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("l3_a_ready_c%0d", c), 32'(rdy1), 32'd0);
      check($sformatf("l3_a_valid_c%0d", c), 32'(rv1), 32'd0);
    end
    @(negedge clk);
    check("l3_a_valid", 32'(rv1), 32'd1);
    check("l3_a_ready", 32'(rdy1), 32'd1);
    check("l3_a_err", 32'(er1), 32'(eer));
    model_txn(1, we, sz, uns, addr, wd, erd, eer);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("l3_b_ready_c%0d", c), 32'(rdy1), 32'd0);
      check($sformatf("l3_b_valid_c%0d", c), 32'(rv1), 32'd0);
    end
    @(negedge clk);
    check("l3_b_valid", 32'(rv1), 32'd1);
    check("l3_b_rdata", rd1, erd);
    @(negedge clk);
    check("l3_b_valid_fall", 32'(rv1), 32'd0);

    // LATENCY=4: reset two cycles into a store discards it.
    txn(2, 1'b1, 2'd2, 1'b0, 16'h0050, 32'h12345678, "rst_prestore");
    @(negedge clk);
    we = 1'b1; sz = 2'd2; uns = 1'b0; addr = 16'h0050; wd = 32'hCAFEBABE;
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rv2), 32'd0);
    check("rst_mid_ready", 32'(rdy2), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid_held", 32'(rv2), 32'd0);
    rst_n = 1'b1;
    txn(2, 1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, "rst_reload");

    // Random traffic in the preloaded window, all sizes including the illegal one.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 60; k++) begin
        txn(d, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom_range(0, 255)),
            $urandom, $sformatf("rnd%0d_%0d", d, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
